sync_adder: RTL and testbench

- Registered N-bit binary adder with carry-in and carry-out; default width 8.
- The sum is computed combinationally by a ripple chain of 1-bit full-adder cells.
- The result is captured on the rising clock edge.
- Used as a clocked arithmetic primitive wherever a registered a+b+cin result is needed one cycle after operands are presented.

---
 rtl/sync_adder.sv | 56 +++++
 tb/tb_sync_adder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_adder.sv
// sync_adder: registered ripple-carry a+b+cin; define SYNC_ADDER_INREG_EN for an extra input register stage (2-cycle latency)
module sync_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH-1:0] w_a, w_b, w_sum;
    logic             w_cin;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
`ifdef SYNC_ADDER_INREG_EN
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_cin;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cin <= 1'b0;
        end else begin
            r_a   <= a;
            r_b   <= b;
            r_cin <= cin;
        end
    end
    assign w_a   = r_a;
    assign w_b   = r_b;
    assign w_cin = r_cin;
`else
    assign w_a   = a;
    assign w_b   = b;
    assign w_cin = cin;
`endif
    assign w_c[0] = w_cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign w_sum[i]  = w_a[i] ^ w_b[i] ^ w_c[i];
        assign w_c[i+1]  = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c[WIDTH];
        end
    end
    assign s    = r_s;
    assign cout = r_cout;
endmodule

// File: tb/tb_sync_adder.sv
// tb_sync_adder: randomized and directed checks of sync_adder at widths 8, 1 and 16 against an arithmetic history model
module tb_sync_adder;
`ifdef SYNC_ADDER_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct packed {
        logic        r;
        logic [8:0]  e8;
        logic [1:0]  e1;
        logic [16:0] e16;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        cin8 = 1'b0, cout8;
    logic        a1 = 1'b0, b1 = 1'b0, s1, cin1 = 1'b0, cout1;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        cin16 = 1'b0, cout16;
    ent_t        hist[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sync_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .cin(cin8),  .s(s8),  .cout(cout8));
    sync_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .a(a1),  .b(b1),  .cin(cin1),  .s(s1),  .cout(cout1));
    sync_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .s(s16), .cout(cout16));

    task automatic tick(input logic r, input logic [7:0] x, input logic [7:0] y, input logic c,
                        output logic v, output logic [8:0] x8, output logic [1:0] x1, output logic [16:0] x16);
        ent_t e;
        logic any_r;
        int   n;
        @(negedge clk);
        rst   = r;
        a8    = x;
        b8    = y;
        cin8  = c;
        a1    = 1'($urandom);
        b1    = 1'($urandom);
        cin1  = 1'($urandom);
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cin16 = 1'($urandom);
        e.r   = r;
        e.e8  = {1'b0, x} + {1'b0, y} + 9'(c);
        e.e1  = {1'b0, a1} + {1'b0, b1} + 2'(cin1);
        e.e16 = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
        hist.push_back(e);
        @(posedge clk);
        #1;
        n = hist.size();
        v = (n >= LAT);
        any_r = 1'b0;
        x8 = '0;
        x1 = '0;
        x16 = '0;
        if (v) begin
            for (int j = 0; j < LAT; j++) any_r |= hist[n-1-j].r;
            if (!any_r) begin
                x8  = hist[n-LAT].e8;
                x1  = hist[n-LAT].e1;
                x16 = hist[n-LAT].e16;
            end
        end
    endtask

    task automatic test_reset();
        logic v;
        logic [8:0] x8;
        logic [1:0] x1;
        logic [16:0] x16;
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 8'hFF, 8'hFF, 1'b1, v, x8, x1, x16);
            checks++;
            if ({cout8, s8} !== 9'h000) begin
                errors++;
                $display("FAIL reset_hold: got %h expected 000", {cout8, s8});
            end
        end
        for (int k = 0; k < LAT; k++) begin
            tick(1'b0, 8'hFF, 8'hFF, 1'b1, v, x8, x1, x16);
            checks++;
            if ({cout8, s8} !== x8) begin
                errors++;
                $display("FAIL reset_release_model: got %h expected %h", {cout8, s8}, x8);
            end
        end
        checks++;
        if ({cout8, s8} !== 9'h1FF) begin
            errors++;
            $display("FAIL reset_release_max: got %h expected 1ff", {cout8, s8});
        end
    endtask

    task automatic test_small();
        logic v;
        logic [8:0] x8;
        logic [1:0] x1;
        logic [16:0] x16;
        logic [7:0] ta[3] = '{8'h01, 8'h03, 8'h01};
        logic [7:0] tb[3] = '{8'h01, 8'h01, 8'h07};
        logic [8:0] te[3] = '{9'h002, 9'h004, 9'h008};
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 20; k++) begin
                tick(1'b0, ta[t], tb[t], 1'b0, v, x8, x1, x16);
                checks++;
                if ({cout8, s8} !== x8) begin
                    errors++;
                    $display("FAIL small_model: got %h expected %h", {cout8, s8}, x8);
                end
            end
            checks++;
            if ({cout8, s8} !== te[t]) begin
                errors++;
                $display("FAIL small_const %0d: got %h expected %h", t, {cout8, s8}, te[t]);
            end
        end
    endtask

    task automatic test_boundary();
        logic v;
        logic [8:0] x8;
        logic [1:0] x1;
        logic [16:0] x16;
        logic [7:0] ta[3] = '{8'h80, 8'h80, 8'h80};
        logic [7:0] tb[3] = '{8'h7F, 8'h7F, 8'hFF};
        logic       tc[3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] te[3] = '{9'h0FF, 9'h100, 9'h17F};
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k <= LAT; k++) tick(1'b0, ta[t], tb[t], tc[t], v, x8, x1, x16);
            checks++;
            if ({cout8, s8} !== te[t]) begin
                errors++;
                $display("FAIL boundary %0d: got %h expected %h", t, {cout8, s8}, te[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic v;
        logic [8:0] x8;
        logic [1:0] x1;
        logic [16:0] x16;
        logic [7:0] ta[6] = '{8'h01, 8'h03, 8'h01, 8'h80, 8'h80, 8'h80};
        logic [7:0] tb[6] = '{8'h01, 8'h01, 8'h07, 8'h7F, 8'h7F, 8'hFF};
        logic       tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < 6; t++) begin
                tick(p == 1 && t == 3, ta[t], tb[t], tc[t], v, x8, x1, x16);
                checks++;
                if ({cout8, s8} !== x8) begin
                    errors++;
                    $display("FAIL b2b pass%0d step%0d: got %h expected %h", p, t, {cout8, s8}, x8);
                end
                if (p == 1 && t == 3) begin
                    checks++;
                    if ({cout8, s8} !== 9'h000) begin
                        errors++;
                        $display("FAIL b2b_mid_reset: got %h expected 000", {cout8, s8});
                    end
                end
            end
        end
        for (int k = 0; k < LAT; k++) begin
            tick(1'b0, 8'h00, 8'h00, 1'b0, v, x8, x1, x16);
            checks++;
            if ({cout8, s8} !== x8) begin
                errors++;
                $display("FAIL b2b_drain: got %h expected %h", {cout8, s8}, x8);
            end
        end
    endtask

    task automatic test_random();
        logic v;
        logic [8:0] x8;
        logic [1:0] x1;
        logic [16:0] x16;
        for (int k = 0; k < 1000; k++) begin
            tick(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), v, x8, x1, x16);
            checks += 3;
            if ({cout8, s8} !== x8) begin
                errors++;
                $display("FAIL rand_w8 %0d: got %h expected %h", k, {cout8, s8}, x8);
            end
            if ({cout1, s1} !== x1) begin
                errors++;
                $display("FAIL rand_w1 %0d: got %h expected %h", k, {cout1, s1}, x1);
            end
            if ({cout16, s16} !== x16) begin
                errors++;
                $display("FAIL rand_w16 %0d: got %h expected %h", k, {cout16, s16}, x16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_boundary();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
